// File: rtl/prm_edge_sweep_packer.sv
// Sweeps a range of checker codes, samples edge_mask per code and
// packs the results LSB-first into words on a valid/ready stream.
module prm_edge_sweep_packer #(
    parameter int WORD_W = 32,
    parameter int CODE_W = 15,
    parameter int CNT_W  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CODE_W-1:0] base_code,
    input  logic [CNT_W-1:0]  edge_count,
    output logic [CODE_W-1:0] chk_code,
    input  logic              chk_mask,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    output logic              word_last,
    input  logic              word_ready,
    output logic [CNT_W:0]    hit_count,
    output logic              busy,
    output logic              done
);

    localparam int BP_W = $clog2(WORD_W);
    localparam int HC_W = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, SWEEP, FLUSH} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  idx, cnt_r;
    logic [BP_W-1:0]   bit_pos;
    logic [WORD_W-1:0] packer, pk_nx;
    logic              is_last, complete, xfer, stall;
    logic              take, accept, fin;

    always_comb begin
        is_last  = (idx == cnt_r - CNT_W'(1));
        complete = (bit_pos == BP_W'(WORD_W - 1)) || is_last;
        xfer     = word_valid && word_ready;
        // a completing sample must not overwrite a word still on offer
        stall    = complete && word_valid && !word_ready;
        accept   = (state == IDLE) && start;
        take     = (state == SWEEP) && !stall;
        fin      = (state == FLUSH) && xfer && word_last;
        pk_nx    = packer;
        pk_nx[bit_pos] = chk_mask;
        state_nx = state;
        unique case (state)
            IDLE:    if (accept && edge_count != '0) state_nx = SWEEP;
            SWEEP:   if (take && is_last) state_nx = FLUSH;
            FLUSH:   if (fin) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_code   <= '0;
            cnt_r      <= '0;
            idx        <= '0;
            bit_pos    <= '0;
            packer     <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            word_last  <= 1'b0;
            hit_count  <= '0;
            done       <= 1'b0;
        end else begin
            done <= (accept && edge_count == '0) || fin;
            if (xfer) word_valid <= 1'b0;
            if (accept) begin
                chk_code  <= base_code;
                cnt_r     <= edge_count;
                idx       <= '0;
                bit_pos   <= '0;
                packer    <= '0;
                hit_count <= '0;
            end
            if (take) begin
                hit_count <= hit_count + HC_W'(chk_mask);
                if (complete) begin
                    word_data  <= pk_nx;
                    word_valid <= 1'b1;
                    word_last  <= is_last;
                    packer     <= '0;
                    bit_pos    <= '0;
                end else begin
                    packer  <= pk_nx;
                    bit_pos <= bit_pos + BP_W'(1);
                end
                if (!is_last) begin
                    idx      <= idx + CNT_W'(1);
                    chk_code <= chk_code + CODE_W'(1);
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_prm_edge_sweep_packer.sv
// Directed bench for prm_edge_sweep_packer with a behavioural
// checker (mask = code[0] or constant 1).
module tb_prm_edge_sweep_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [14:0] base_code = '0;
    logic [14:0] edge_count = '0;
    logic [14:0] chk_code;
    logic        chk_mask;
    logic [31:0] word_data;
    logic        word_valid, word_last;
    logic        word_ready = 1'b1;
    logic [15:0] hit_count;
    logic        busy, done;

    prm_edge_sweep_packer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .base_code(base_code), .edge_count(edge_count),
        .chk_code(chk_code), .chk_mask(chk_mask),
        .word_data(word_data), .word_valid(word_valid),
        .word_last(word_last), .word_ready(word_ready),
        .hit_count(hit_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic mode = 1'b0;
    always_comb chk_mask = mode ? 1'b1 : chk_code[0];

    int n_cmp = 0, n_err = 0;
    int cyc = 0, done_n = 0, done_cyc = 0;
    bit vseen = 0, bseen = 0;
    logic [31:0] wq[$];
    logic        lq[$];
    int          tq[$];
    logic [14:0] cq[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (word_valid && word_ready) begin
            wq.push_back(word_data);
            lq.push_back(word_last);
            tq.push_back(cyc);
        end
        if (word_valid) vseen = 1;
        if (busy) bseen = 1;
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (busy && (cq.size() == 0 || cq[$] != chk_code))
            cq.push_back(chk_code);
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        wq.delete(); lq.delete(); tq.delete(); cq.delete();
        vseen = 0; bseen = 0; done_n = 0;
    endtask

    task automatic go(input logic [14:0] b, input logic [14:0] n);
        @(posedge clk); #1;
        start = 1; base_code = b; edge_count = n;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(string tag);
        int t = 0;
        while (done_n == 0 && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        chk({tag, "_timeout"}, 64'(t < 400), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #12;
        chk("rst_code", 64'(chk_code), 0);
        chk("rst_valid", 64'(word_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_hits", 64'(hit_count), 0);
        @(posedge clk); #1;
        rst_n = 1;

        // empty sweep
        clr();
        go(15'h0123, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("e0_done_n", 64'(done_n), 1);
        chk("e0_busy", 64'(bseen), 0);
        chk("e0_valid", 64'(vseen), 0);
        chk("e0_hits", 64'(hit_count), 0);

        // 5 codes from 0x10, mask = code[0]
        clr();
        mode = 0;
        go(15'h0010, 5);
        wait_done("c5");
        chk("c5_ncodes", 64'(cq.size()), 5);
        for (int i = 0; i < 5 && i < cq.size(); i++)
            chk("c5_code", 64'(cq[i]), 64'(16 + i));
        chk("c5_nwords", 64'(wq.size()), 1);
        if (wq.size() == 1) begin
            chk("c5_word", 64'(wq[0]), 64'h0000000A);
            chk("c5_last", 64'(lq[0]), 1);
            chk("c5_done_lat", 64'(done_cyc), 64'(tq[0] + 1));
        end
        chk("c5_hits", 64'(hit_count), 2);
        chk("c5_done_n", 64'(done_n), 1);
        chk("c5_busy", 64'(busy), 0);

        // 33 ones: second word follows without a bubble
        clr();
        mode = 1;
        go(15'h0000, 33);
        wait_done("c33");
        chk("c33_nwords", 64'(wq.size()), 2);
        if (wq.size() == 2) begin
            chk("c33_w0", 64'(wq[0]), 64'hFFFFFFFF);
            chk("c33_l0", 64'(lq[0]), 0);
            chk("c33_w1", 64'(wq[1]), 64'h00000001);
            chk("c33_l1", 64'(lq[1]), 1);
            chk("c33_b2b", 64'(tq[1] - tq[0]), 1);
        end
        chk("c33_hits", 64'(hit_count), 33);

        // 70 codes with back-pressure on word0
        clr();
        mode = 0;
        word_ready = 0;
        go(15'h0000, 70);
        begin
            int t = 0;
            while (!word_valid && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            chk("c70_w0_timeout", 64'(t < 100), 1);
        end
        repeat (40) @(posedge clk);
        #1;
        chk("c70_freeze_code", 64'(chk_code), 63);
        chk("c70_hold_data", 64'(word_data), 64'hAAAAAAAA);
        chk("c70_hold_last", 64'(word_last), 0);
        chk("c70_hold_valid", 64'(word_valid), 1);
        chk("c70_stall_hits", 64'(hit_count), 31);
        chk("c70_no_xfer", 64'(wq.size()), 0);
        word_ready = 1;
        wait_done("c70");
        chk("c70_nwords", 64'(wq.size()), 3);
        if (wq.size() == 3) begin
            chk("c70_w0", 64'(wq[0]), 64'hAAAAAAAA);
            chk("c70_w1", 64'(wq[1]), 64'hAAAAAAAA);
            chk("c70_w2", 64'(wq[2]), 64'h0000002A);
            chk("c70_lasts", 64'({lq[0], lq[1], lq[2]}), 64'b001);
        end
        chk("c70_hits", 64'(hit_count), 35);

        // code wrap 0x7FFE..0x0001
        clr();
        go(15'h7FFE, 4);
        wait_done("wrap");
        chk("wrap_ncodes", 64'(cq.size()), 4);
        if (cq.size() == 4) begin
            chk("wrap_c0", 64'(cq[0]), 64'h7FFE);
            chk("wrap_c1", 64'(cq[1]), 64'h7FFF);
            chk("wrap_c2", 64'(cq[2]), 64'h0000);
            chk("wrap_c3", 64'(cq[3]), 64'h0001);
        end
        chk("wrap_nwords", 64'(wq.size()), 1);
        if (wq.size() == 1) chk("wrap_word", 64'(wq[0]), 64'h0000000A);
        chk("wrap_hits", 64'(hit_count), 2);

        // reset mid-sweep, then a clean sweep
        clr();
        mode = 1;
        go(15'h0000, 40);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("mr_code", 64'(chk_code), 0);
        chk("mr_busy", 64'(busy), 0);
        chk("mr_valid", 64'(word_valid), 0);
        chk("mr_hits", 64'(hit_count), 0);
        chk("mr_data", 64'(word_data), 0);
        @(posedge clk); #1;
        rst_n = 1;
        clr();
        mode = 0;
        go(15'h0100, 5);
        wait_done("mr");
        chk("mr_nwords", 64'(wq.size()), 1);
        if (wq.size() == 1) begin
            chk("mr_word", 64'(wq[0]), 64'h0000000A);
            chk("mr_last", 64'(lq[0]), 1);
        end
        chk("mr_hits2", 64'(hit_count), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
